// File: rtl/fpu_mc_issue_if.sv
// Bundle between fpu_mc_issue, the requesting core and the sqrt/divide units.
// master = the issue block; slave = everything that talks to it.
interface fpu_mc_issue_if #(
    parameter int RD_W = 6
);
    // Handshakes:
    //   issue: a request is taken on a rising edge where issue_valid=1 and busy=0.
    //     The requester holds issue_* stable until that edge.
    //   unit:  *_ready is a one-cycle start pulse.
    //     The unit samples its operands on the edge that ends that pulse.
    //     It later answers with a one-cycle *_valid pulse, with *_y alongside it.
    //   wb:    wb_en is a one-cycle strobe.
    //     wb_rd, wb_data and wb_err are meaningful only while wb_en=1.
    logic            issue_valid;
    logic [1:0]      issue_op;
    logic [31:0]     issue_a;
    logic [31:0]     issue_b;
    logic [RD_W-1:0] issue_rd;
    logic            busy;
    logic [31:0]     sqrt_x1;
    logic            sqrt_ready;
    logic [31:0]     sqrt_y;
    logic            sqrt_valid;
    logic [31:0]     div_x1;
    logic [31:0]     div_x2;
    logic            div_ready;
    logic [31:0]     div_y;
    logic            div_valid;
    logic            wb_en;
    logic [RD_W-1:0] wb_rd;
    logic [31:0]     wb_data;
    logic            wb_err;

    modport master (
        input  issue_valid, issue_op, issue_a, issue_b, issue_rd,
        input  sqrt_y, sqrt_valid, div_y, div_valid,
        output busy, sqrt_x1, sqrt_ready, div_x1, div_x2, div_ready,
        output wb_en, wb_rd, wb_data, wb_err
    );

    modport slave (
        output issue_valid, issue_op, issue_a, issue_b, issue_rd,
        output sqrt_y, sqrt_valid, div_y, div_valid,
        input  busy, sqrt_x1, sqrt_ready, div_x1, div_x2, div_ready,
        input  wb_en, wb_rd, wb_data, wb_err
    );
endinterface

// File: rtl/fpu_mc_issue.sv
// Single-op initiator for the multi-cycle sqrt/divide units with registered writeback.
// Optional WAIT-state abort is enabled by defining FPU_MC_TIMEOUT_EN.
module fpu_mc_issue #(
    parameter int TIMEOUT = 32,
    parameter int RD_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    fpu_mc_issue_if.master    bus,
    output logic [1:0]        state_dbg
);

    if (TIMEOUT < 4 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fpu_mc_issue: TIMEOUT must be within 4..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            div_sel_q, div_sel_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [31:0]     sqrt_x1_q, sqrt_x1_d;
    logic [31:0]     div_x1_q, div_x1_d;
    logic [31:0]     div_x2_q, div_x2_d;
    logic            sqrt_ready_q, sqrt_ready_d;
    logic            div_ready_q, div_ready_d;
    logic            wb_en_q, wb_en_d;
    logic [RD_W-1:0] wb_rd_q, wb_rd_d;
    logic [31:0]     wb_data_q, wb_data_d;

    logic accept;
    logic sel_valid;
    logic timeout_hit;

    assign accept    = bus.issue_valid && (state_q == IDLE);
    // Only the unit that owns the in-flight op may complete it.
    assign sel_valid = div_sel_q ? bus.div_valid : bus.sqrt_valid;

`ifdef FPU_MC_TIMEOUT_EN
    logic [7:0] tmo_q;
    logic       wb_err_q, wb_err_d;

    assign timeout_hit = (state_q == WAIT) && (tmo_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q    <= 8'd0;
            wb_err_q <= 1'b0;
        end else begin
            wb_err_q <= wb_err_d;
            if (state_q == ISSUE) begin
                tmo_q <= 8'd0;
            end else if (state_q == WAIT) begin
                tmo_q <= tmo_q + 8'd1;
            end
        end
    end

    assign bus.wb_err = wb_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.wb_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && !bus.issue_op[1]) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (sel_valid || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_sel_d    = div_sel_q;
        rd_d         = rd_q;
        sqrt_x1_d    = sqrt_x1_q;
        div_x1_d     = div_x1_q;
        div_x2_d     = div_x2_q;
        sqrt_ready_d = 1'b0;
        div_ready_d  = 1'b0;
        wb_en_d      = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
`ifdef FPU_MC_TIMEOUT_EN
        wb_err_d     = wb_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    div_sel_d = bus.issue_op[0];
                    rd_d      = bus.issue_rd;
                    if (bus.issue_op == 2'd0) begin
                        sqrt_x1_d    = bus.issue_a;
                        sqrt_ready_d = 1'b1;
                    end else if (bus.issue_op == 2'd1) begin
                        div_x1_d    = bus.issue_a;
                        div_x2_d    = bus.issue_b;
                        div_ready_d = 1'b1;
                    end else begin
                        // Moves never touch a unit; write back straight away.
                        wb_en_d   = 1'b1;
                        wb_rd_d   = bus.issue_rd;
                        wb_data_d = bus.issue_a;
`ifdef FPU_MC_TIMEOUT_EN
                        wb_err_d  = 1'b0;
`endif
                    end
                end
            end
            WAIT: begin
                if (sel_valid) begin
                    wb_en_d   = 1'b1;
                    wb_rd_d   = rd_q;
                    wb_data_d = div_sel_q ? bus.div_y : bus.sqrt_y;
`ifdef FPU_MC_TIMEOUT_EN
                    wb_err_d  = 1'b0;
`endif
                end else if (timeout_hit) begin
                    wb_en_d   = 1'b1;
                    wb_rd_d   = rd_q;
                    wb_data_d = 32'h7FC0_0000;
`ifdef FPU_MC_TIMEOUT_EN
                    wb_err_d  = 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_sel_q    <= 1'b0;
            rd_q         <= '0;
            sqrt_x1_q    <= 32'd0;
            div_x1_q     <= 32'd0;
            div_x2_q     <= 32'd0;
            sqrt_ready_q <= 1'b0;
            div_ready_q  <= 1'b0;
            wb_en_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= 32'd0;
        end else begin
            div_sel_q    <= div_sel_d;
            rd_q         <= rd_d;
            sqrt_x1_q    <= sqrt_x1_d;
            div_x1_q     <= div_x1_d;
            div_x2_q     <= div_x2_d;
            sqrt_ready_q <= sqrt_ready_d;
            div_ready_q  <= div_ready_d;
            wb_en_q      <= wb_en_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.sqrt_x1    = sqrt_x1_q;
    assign bus.sqrt_ready = sqrt_ready_q;
    assign bus.div_x1     = div_x1_q;
    assign bus.div_x2     = div_x2_q;
    assign bus.div_ready  = div_ready_q;
    assign bus.wb_en      = wb_en_q;
    assign bus.wb_rd      = wb_rd_q;
    assign bus.wb_data    = wb_data_q;
    assign state_dbg      = state_q;

endmodule
